// File: rtl/wb_pkg.sv
// Shared constants, entry type, occupancy encoding and one-hot decode for the
// register writeback unit.
package wb_pkg;

    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [REG_W-1:0]  data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

    // R0 is hard-wired, so its select line never asserts.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [ADDR_W-1:0] rd);
        reg_onehot = '0;
        if (rd != '0) reg_onehot[rd] = 1'b1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Pending-write queue: DEPTH entries with push/pop, occupancy FSM, and all
// entries exposed so the bypass search can see them.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                push_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output wb_entry_t                head,
    output wb_entry_t                entries [DEPTH]
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    occ_t              state, state_next;
    logic              push_ok, pop_ok;

    assign push_ok = push && (state != OCC_FULL);
    assign pop_ok  = pop && (state != OCC_EMPTY);
    assign full    = (state == OCC_FULL);
    assign head    = mem[rd_ptr];
    assign entries = mem;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_entry;
    end

    // Pointer width equals log2(DEPTH), so wrap-around is the natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= OCC_EMPTY;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            OCC_EMPTY: begin
                if (push_ok) state_next = OCC_PARTIAL;
            end
            OCC_PARTIAL: begin
                if (push_ok && !pop_ok && count == CW'(DEPTH - 1))
                    state_next = OCC_FULL;
                else if (pop_ok && !push_ok && count == CW'(1))
                    state_next = OCC_EMPTY;
            end
            OCC_FULL: begin
                if (pop_ok) state_next = OCC_PARTIAL;
            end
            default: state_next = OCC_EMPTY;
        endcase
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Register writeback unit: queues write requests, drains one per cycle into
// registered strobe/select/data outputs. Optional bypass search: WB_BYPASS_EN.
module reg_writeback_unit
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_rd,
    input  logic [REG_W-1:0]       in_data,
    output logic                   regWrite,
    output logic [NREGS-1:0]       decOut,
    output logic [REG_W-1:0]       writeData,
    input  logic [ADDR_W-1:0]      rs_addr,
    input  logic [ADDR_W-1:0]      rt_addr,
    output logic                   rs_hit,
    output logic                   rt_hit,
    output logic [REG_W-1:0]       rs_data,
    output logic [REG_W-1:0]       rt_data,
    output logic [$clog2(DEPTH):0] pend_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          push, pop, full;
    logic [PW-1:0] rd_ptr;
    wb_entry_t     head;
    wb_entry_t     entries [DEPTH];
    logic [ADDR_W-1:0] out_rd;

    assign in_ready = !full && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = (pend_cnt != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .push_entry ('{rd: in_rd, data: in_data}),
        .count      (pend_cnt),
        .full       (full),
        .rd_ptr     (rd_ptr),
        .head       (head),
        .entries    (entries)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            regWrite  <= 1'b0;
            decOut    <= '0;
            writeData <= '0;
            out_rd    <= '0;
        end else if (pop) begin
            regWrite  <= (head.rd != '0);
            decOut    <= reg_onehot(head.rd);
            writeData <= head.data;
            out_rd    <= head.rd;
        end else begin
            regWrite <= 1'b0;
            decOut   <= '0;
        end
    end

    logic             rs_hit_c, rt_hit_c;
    logic [REG_W-1:0] rs_data_c, rt_data_c;
    logic [PW-1:0]    idx;

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        rs_hit_c  = 1'b0;
        rt_hit_c  = 1'b0;
        rs_data_c = '0;
        rt_data_c = '0;
        idx       = '0;
        if (regWrite && out_rd == rs_addr) begin
            rs_hit_c  = 1'b1;
            rs_data_c = writeData;
        end
        if (regWrite && out_rd == rt_addr) begin
            rt_hit_c  = 1'b1;
            rt_data_c = writeData;
        end
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < pend_cnt) begin
                if (entries[idx].rd == rs_addr) begin
                    rs_hit_c  = 1'b1;
                    rs_data_c = entries[idx].data;
                end
                if (entries[idx].rd == rt_addr) begin
                    rt_hit_c  = 1'b1;
                    rt_data_c = entries[idx].data;
                end
            end
        end
        if (rs_addr == '0) begin
            rs_hit_c  = 1'b0;
            rs_data_c = '0;
        end
        if (rt_addr == '0) begin
            rt_hit_c  = 1'b0;
            rt_data_c = '0;
        end
    end

`ifdef WB_BYPASS_EN
    assign rs_hit  = rs_hit_c;
    assign rt_hit  = rt_hit_c;
    assign rs_data = rs_data_c;
    assign rt_data = rt_data_c;
`else
    logic unused_bypass;
    assign unused_bypass = ^{rs_hit_c, rt_hit_c, rs_data_c, rt_data_c};
    assign rs_hit  = 1'b0;
    assign rt_hit  = 1'b0;
    assign rs_data = '0;
    assign rt_data = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit with a queue scoreboard of pending
// writes; bypass expectations follow WB_BYPASS_EN.
module tb_reg_writeback_unit;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready;
    logic [4:0]    in_rd, rs_addr, rt_addr;
    logic [31:0]   in_data, decOut, writeData, rs_data, rt_data;
    logic          regWrite, rs_hit, rt_hit;
    logic [CW-1:0] pend_cnt;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        sb[$];
    logic        exp_rw;
    logic [31:0] exp_dec, exp_wd;
    logic [4:0]  exp_rd;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    reg_writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .regWrite  (regWrite),
        .decOut    (decOut),
        .writeData (writeData),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_hit    (rs_hit),
        .rt_hit    (rt_hit),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .pend_cnt  (pend_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Youngest-first search over the scoreboard, then the output register.
    task automatic bypass_exp(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a != 5'd0) begin
            for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
                if (!h && sb[i].rd == a) begin
                    h = 1'b1;
                    d = sb[i].data;
                end
            end
            if (!h && exp_rw && exp_rd == a) begin
                h = 1'b1;
                d = exp_wd;
            end
        end
`ifndef WB_BYPASS_EN
        h = 1'b0;
        d = '0;
`endif
    endtask

    task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d,
                        input logic rst);
        logic        accept, h;
        logic [31:0] bd;
        ent_t        e;
        reset    = rst;
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!rst && sb.size() < DEPTH)});
        accept = v && !rst && (sb.size() < DEPTH);
        @(posedge clk);
        if (rst) begin
            sb.delete();
            exp_rw  = 1'b0;
            exp_dec = '0;
            exp_wd  = '0;
            exp_rd  = '0;
        end else begin
            if (sb.size() != 0) begin
                e       = sb.pop_front();
                exp_rw  = (e.rd != 5'd0);
                exp_dec = (e.rd == 5'd0) ? 32'd0 : (32'd1 << e.rd);
                exp_wd  = e.data;
                exp_rd  = e.rd;
            end else begin
                exp_rw  = 1'b0;
                exp_dec = '0;
            end
            if (accept) sb.push_back('{rd, d});
        end
        @(negedge clk);
        chk("regWrite", {31'd0, regWrite}, {31'd0, exp_rw});
        chk("decOut", decOut, exp_dec);
        chk("writeData", writeData, exp_wd);
        chk("pend_cnt", {{(32-CW){1'b0}}, pend_cnt}, sb.size());
        bypass_exp(rs_addr, h, bd);
        chk("rs_hit", {31'd0, rs_hit}, {31'd0, h});
        chk("rs_data", rs_data, bd);
        bypass_exp(rt_addr, h, bd);
        chk("rt_hit", {31'd0, rt_hit}, {31'd0, h});
        chk("rt_data", rt_data, bd);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_rd    = '0;
        in_data  = '0;
        rs_addr  = '0;
        rt_addr  = '0;
        exp_rw   = 1'b0;
        exp_dec  = '0;
        exp_wd   = '0;
        exp_rd   = '0;
        @(negedge clk);

        // Reset state
        step(1'b1, 5'd3, 32'h1111_1111, 1'b1);
        step(1'b0, 5'd0, 32'h0, 1'b1);

        // Single write to R5, one-cycle latency, then strobe drops, data holds
        rs_addr = 5'd5;
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0);

        // Write to R0 is discarded
        step(1'b1, 5'd0, 32'h0000_1234, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0);

        // Back-to-back pushes DEPTH+1 long; strict order, pointer wrap
        rs_addr = 5'd3;
        rt_addr = 5'd2;
        for (int i = 1; i <= DEPTH + 1; i++)
            step(1'b1, 5'(i), 32'hA000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 5'd0, 32'h0, 1'b0);

        // Two writes to R7: youngest value forwarded, rt_addr=0 never hits
        rs_addr = 5'd7;
        rt_addr = 5'd0;
        step(1'b1, 5'd7, 32'h0000_000A, 1'b0);
        step(1'b1, 5'd7, 32'h0000_000B, 1'b0);
        rt_addr = 5'd7;
        step(1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0);

        // Reset mid-drain drops queued writes; no stale strobe afterwards
        step(1'b1, 5'd9, 32'h0000_0009, 1'b0);
        step(1'b1, 5'd10, 32'h0000_0010, 1'b0);
        step(1'b1, 5'd11, 32'h0000_0011, 1'b1);
        step(1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            rs_addr = 5'($urandom_range(0, 7));
            rt_addr = 5'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, 1'b0);
        end
        for (int i = 0; i < 3; i++)
            step(1'b0, 5'd0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
